// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM with memready stalls and a post-reset fetch hold.
// Optional BNE support is compiled in when MC_BNE_EN is defined.
module mc_ctrl #(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       illegal_q, illegal_d;
  logic       pcwrite, branch, branch_ne;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      hold_q    <= RESET_PC_HOLD[3:0];
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    hold_d    = hold_q;
    illegal_d = illegal_q;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    iord      = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        if (hold_q != 4'd0) begin
          hold_d  = hold_q - 4'd1;
          state_d = FETCH;
        end else begin
          irwrite = memready;
          pcwrite = memready;
          state_d = memready ? DECODE : FETCH;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = memready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase

    pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);

    // Reset gates outputs combinationally so an in-flight write drops immediately.
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      iord     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      pcen     = 1'b0;
    end
  end

  assign illegal = illegal_q & ~reset;
  assign state   = reset ? FETCH : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with RESET_PC_HOLD=2; expected output vectors are hand-derived.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset, zero, memready;
  logic [5:0] op;
  logic       memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;
  logic [18:0] obs;
  int n_assert = 0;
  int n_fail   = 0;

  mc_ctrl #(.RESET_PC_HOLD(2)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .memwrite(memwrite), .irwrite(irwrite), .iord(iord), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal, state};

  function automatic logic [18:0] mk(input logic mw, irw, io, rw, rd, mtr, asa,
                                     input logic [1:0] asb, pcs, aop,
                                     input logic pce, ill, input logic [3:0] st);
    return {mw, irw, io, rw, rd, mtr, asa, asb, pcs, aop, pce, ill, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    #1;
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; zero = 1'b0; memready = 1'b1;
    tick(); tick();
    chk("reset_outputs", mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd0));

    // lw after reset: two hold cycles, then 0,1,2,3,4,0
    reset = 1'b0;
    chk("hold_1",   mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));
    tick(); chk("hold_2",   mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));
    tick(); chk("lw_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); chk("lw_decode",mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); chk("lw_memadr",mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,4'd2));
    tick(); chk("lw_memrd", mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd3));
    tick(); chk("lw_memwb", mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,4'd4));

    // sw with three stalled MEMWR cycles
    tick(); op = 6'b101011;
    chk("sw_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); chk("sw_decode",mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); chk("sw_memadr",mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,4'd2));
    tick(); memready = 1'b0;
    chk("sw_stall_1", mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd5));
    tick(); chk("sw_stall_2", mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd5));
    tick(); chk("sw_stall_3", mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd5));
    tick(); memready = 1'b1;
    chk("sw_done", mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd5));

    // beq; memready low through DECODE/BEQEX must not stall
    tick(); op = 6'b000100; zero = 1'b1;
    chk("beq_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); memready = 1'b0;
    chk("beq_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); chk("beq_taken", mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,4'd8));
    zero = 1'b0;
    chk("beq_not_taken", mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,4'd8));

    // R-type then addi, back to back
    tick(); memready = 1'b1; op = 6'b000000;
    chk("rt_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); chk("rt_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); chk("rt_ex", mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0,0,4'd6));
    op = 6'b001000;
    tick(); chk("rt_wb", mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0,4'd7));
    tick(); chk("addi_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); chk("addi_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); chk("addi_ex", mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,4'd9));
    tick(); chk("addi_wb", mk(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,4'd10));

    // illegal opcode, then j still runs
    tick(); op = 6'b111111;
    chk("ill_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); chk("ill_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1));
    tick(); op = 6'b000010;
    chk("ill_back_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,1,4'd0));
    tick(); chk("j_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,4'd1));
    tick(); chk("j_ex", mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,1,4'd11));

    // op 000101: BNE when enabled, otherwise illegal
    tick(); op = 6'b000101;
    chk("bne_fetch", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,1,4'd0));
    tick(); chk("bne_decode", mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,4'd1));
    tick();
`ifdef MC_BNE_EN
    chk("bne_taken", mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,1,4'd12));
    tick();
`endif
    chk("bne_after", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,1,4'd0));

    // reset clears illegal and reloads the hold counter
    reset = 1'b1;
    chk("reset_again", mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd0));
    tick(); reset = 1'b0; memready = 1'b0;
    chk("rst_hold_1", mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));
    tick(); chk("rst_hold_2", mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));
    for (int i = 0; i < 5; i++) begin
      tick(); chk("fetch_stall", mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));
    end
    memready = 1'b1; op = 6'b100011;
    chk("fetch_release", mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,4'd0));
    tick(); tick(); tick(); memready = 1'b0;
    chk("memrd_stall_1", mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd3));
    tick(); chk("memrd_stall_2", mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd3));
    reset = 1'b1;
    chk("memrd_reset_now", mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd0));
    tick(); reset = 1'b0;
    chk("memrd_reset_after", mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences the shared ALU, memory port, instruction register and register file over 3-5 cycles per instruction.
- Drives aluop into aludec, which returns alucontrol to the datapath.
- Supports a memory ready handshake so a slow unified memory can stall any memory-access state.

Parameters:
- RESET_PC_HOLD, 0, number of extra cycles held in FETCH after reset deassertion before the first fetch (0..15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- memready  input  1  memory completed the current access this cycle.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  load instruction register.
- iord  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- regwrite  output  1  register file write enable.
- regdst  output  1  1 = rd is the destination; 0 = rt.
- memtoreg  output  1  1 = write-back from data register; 0 = from ALUOut.
- alusrca  output  1  0 = PC; 1 = register A.
- alusrcb  output  2  00 = B; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate shifted left 2.
- pcsrc  output  2  00 = ALU result; 01 = ALUOut; 10 = jump target.
- aluop  output  2  00 = add; 01 = subtract; 10 = funct decode.
- pcen  output  1  PC load enable = pcwrite OR (branch AND zero).
- illegal  output  1  sticky flag, set when an unknown opcode is decoded.
- state  output  4  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- While reset=1: every output is 0, except state=FETCH (0). On each edge with reset=1: state<=FETCH, illegal<=0, hold counter<=RESET_PC_HOLD.
- Moore outputs: all outputs decode from state only, except pcen, which also uses zero, and the memready gating below. Signals not listed for a state are 0.
- State encodings and transitions:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
    - hold counter != 0: decrement the counter, all strobes 0.
    - Otherwise irwrite and pcwrite equal memready.
    - memready=1 -> DECODE; else stay in FETCH.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00 (branch target precompute). Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other op -> FETCH, and illegal<=1.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. op=100011 -> MEMRD; else MEMWR.
  - MEMRD(3): iord=1. memready=1 -> MEMWB; else stay.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR(5): iord=1, memwrite=1 held every cycle until memready=1 -> FETCH.
  - RTYPEEX(6): alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BEQEX(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JEX(11): pcsrc=10, pcwrite=1 -> FETCH.
- Unused encodings 12-15: all outputs 0; next state FETCH.
- Cycle counts with memready tied to 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Boundary conditions:
  - Reset during any state, including a stalled MEMWR, aborts the access. memwrite drops in the same cycle reset is seen.
  - illegal stays set until reset. Subsequent instructions execute normally.
  - memready is ignored in states that do not access memory.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - op 000101 in DECODE -> BNEEX (encoding 12).
  - BNEEX uses the same ALU settings as BEQEX.
  - pcen = NOT zero; next state FETCH.
- Undefined: op 000101 is illegal (DECODE -> FETCH, illegal<=1). Encoding 12 behaves as an unused encoding.

Test Plan:
- Reset, then lw with RESET_PC_HOLD=2 and memready=1: 2 hold cycles, then states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
- sw with memready low for 3 cycles in MEMWR: memwrite=1 for exactly 4 cycles, and pcen=0 throughout.
- beq with zero=1: pcen=1 in BEQEX, pcsrc=01. With zero=0: pcen=0. Both take 3 cycles.
- R-type then addi back to back: aluop=10 in state 6, regdst=1 in state 7. Then addi state 10 has regdst=0. 8 cycles total.
- op=111111: DECODE -> FETCH and illegal=1. Next j still executes (state 11, pcsrc=10, pcen=1). Reset clears illegal.
- Stall in FETCH with memready=0 for 5 cycles: irwrite=0 and pcen=0, state stays 0. Assert reset while MEMRD is stalled: state=0 next cycle.
